// File: rtl/base64_pkg.sv
// rtl/base64_pkg.sv - shared state, error code and character constants for the Base64 stream decoder
package base64_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CHAR  = 2'd1;
  localparam logic [1:0] ERR_PAD   = 2'd2;
  localparam logic [1:0] ERR_TRUNC = 2'd3;

  localparam logic [7:0] PAD_CHAR = 8'h3D;

  localparam logic [7:0] WS_TAB = 8'h09;
  localparam logic [7:0] WS_LF  = 8'h0A;
  localparam logic [7:0] WS_CR  = 8'h0D;
  localparam logic [7:0] WS_SP  = 8'h20;

endpackage

// File: rtl/base64_char_dec.sv
// rtl/base64_char_dec.sv - ASCII to sextet map; BASE64_DEC_WS_SKIP_EN turns CR/LF/SP/TAB into skippable whitespace
module base64_char_dec
  import base64_pkg::*;
(
  input  logic [7:0] in_data,
  output logic [5:0] sextet,
  output logic       is_pad,
  output logic       is_ws,
  output logic       is_bad
);

`ifdef BASE64_DEC_WS_SKIP_EN
  localparam bit WS_SKIP = 1'b1;
`else
  localparam bit WS_SKIP = 1'b0;
`endif

  logic hit;
  logic ws_char;

  // Pad and unmapped characters leave sextet at 0 so the accumulator shifts in zeros
  always_comb begin
    sextet = 6'd0;
    hit    = 1'b1;
    if (in_data >= 8'h41 && in_data <= 8'h5A) begin
      sextet = 6'(in_data - 8'h41);
    end else if (in_data >= 8'h61 && in_data <= 8'h7A) begin
      sextet = 6'(in_data - 8'h61 + 8'd26);
    end else if (in_data >= 8'h30 && in_data <= 8'h39) begin
      sextet = 6'(in_data - 8'h30 + 8'd52);
    end else if (in_data == 8'h2B) begin
      sextet = 6'd62;
    end else if (in_data == 8'h2F) begin
      sextet = 6'd63;
    end else begin
      hit = 1'b0;
    end
  end

  assign ws_char = (in_data == WS_TAB) || (in_data == WS_LF) ||
                   (in_data == WS_CR)  || (in_data == WS_SP);
  assign is_pad  = (in_data == PAD_CHAR);
  assign is_ws   = ws_char && WS_SKIP;
  assign is_bad  = !hit && !is_pad && !is_ws;

endmodule

// File: rtl/base64_dec_stream.sv
// rtl/base64_dec_stream.sv - streaming Base64 decoder, 4 chars in, up to 3 bytes out
// Optional: define BASE64_DEC_WS_SKIP_EN to drop CR/LF/SP/TAB instead of flagging them invalid.
module base64_dec_stream
  import base64_pkg::*;
#(
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err,
  output logic [1:0] err_code
);

  state_e      state;
  state_e      state_nxt;
  logic [23:0] acc;
  logic [1:0]  cnt;
  logic        pad_seen;
  logic [1:0]  nbytes;
  logic        grp_last;
  logic [1:0]  bidx;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic        err_nxt;

  logic [5:0]  sextet;
  logic        is_pad;
  logic        is_ws;
  logic        is_bad;

  logic        accept;
  logic        collect_acc;
  logic [1:0]  chk_code;
  logic        char_err;
  logic        grp_done;
  logic        last_byte;
  logic [7:0]  byte_sel;

  base64_char_dec u_char_dec (
    .in_data (in_data),
    .sextet  (sextet),
    .is_pad  (is_pad),
    .is_ws   (is_ws),
    .is_bad  (is_bad)
  );

  assign in_ready    = rst_n && (state == COLLECT || state == DRAIN);
  assign accept      = in_valid && in_ready;
  assign collect_acc = accept && (state == COLLECT);

  // Checks are ordered so the most fundamental fault wins when several apply
  always_comb begin
    chk_code = ERR_NONE;
    if (is_bad) begin
      chk_code = ERR_CHAR;
    end else if (is_ws) begin
      chk_code = in_last ? ERR_TRUNC : ERR_NONE;
    end else if (is_pad && cnt < 2'd2) begin
      chk_code = ERR_PAD;
    end else if (!is_pad && cnt == 2'd3 && pad_seen) begin
      chk_code = ERR_PAD;
    end else if (in_last && cnt != 2'd3) begin
      chk_code = ERR_TRUNC;
    end else if (is_pad && cnt == 2'd3 && !in_last) begin
      chk_code = ERR_PAD;
    end
  end

  assign char_err  = collect_acc && (chk_code != ERR_NONE);
  assign grp_done  = collect_acc && (chk_code == ERR_NONE) && !is_ws && (cnt == 2'd3);
  assign last_byte = (bidx == nbytes - 2'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (char_err) begin
          state_nxt = in_last ? COLLECT : DRAIN;
        end else if (grp_done) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready && last_byte) begin
          state_nxt = COLLECT;
        end
      end
      DRAIN: begin
        if (accept && in_last) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Sticky mode keeps err up for as long as the frame is being drained
  assign err_nxt = char_err || (ERR_STICKY && state_nxt == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      acc        <= 24'd0;
      cnt        <= 2'd0;
      pad_seen   <= 1'b0;
      nbytes     <= 2'd0;
      grp_last   <= 1'b0;
      bidx       <= 2'd0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (char_err) begin
        err_code_q <= chk_code;
      end else if (!err_nxt) begin
        err_code_q <= ERR_NONE;
      end

      if (char_err) begin
        cnt      <= 2'd0;
        pad_seen <= 1'b0;
      end else if (collect_acc && !is_ws) begin
        acc <= {acc[17:0], sextet};
        // cnt wraps back to 0 on the fourth character
        cnt <= cnt + 2'd1;
        if (is_pad && cnt == 2'd2) begin
          pad_seen <= 1'b1;
        end
        if (cnt == 2'd3) begin
          nbytes   <= pad_seen ? 2'd1 : (is_pad ? 2'd2 : 2'd3);
          grp_last <= in_last;
          bidx     <= 2'd0;
          pad_seen <= 1'b0;
        end
      end

      if (state == EMIT && out_ready) begin
        bidx <= last_byte ? 2'd0 : bidx + 2'd1;
      end
    end
  end

  always_comb begin
    case (bidx)
      2'd0:    byte_sel = acc[23:16];
      2'd1:    byte_sel = acc[15:8];
      default: byte_sel = acc[7:0];
    endcase
  end

  assign out_valid = rst_n && (state == EMIT);
  assign out_data  = out_valid ? byte_sel : 8'h00;
  assign out_last  = out_valid && grp_last && last_byte;
  assign err       = rst_n && err_q;
  assign err_code  = err ? err_code_q : ERR_NONE;

endmodule

// File: tb/tb_base64_dec_stream.sv
// tb/tb_base64_dec_stream.sv - randomized self-checking bench for base64_dec_stream against a frame-level model
module tb_base64_dec_stream;

  localparam bit STICKY = 1'b1;
`ifdef BASE64_DEC_WS_SKIP_EN
  localparam bit WS_SKIP = 1'b1;
`else
  localparam bit WS_SKIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;
  int rdy_mode;
  int gap_en;

  string B64 = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
  logic [7:0] bad_chars [6] = '{8'h2A, 8'h21, 8'h2D, 8'h2E, 8'h20, 8'h0D};

  logic [7:0] frame_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         got_err_q[$];

  base64_dec_stream #(.ERR_STICKY(STICKY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sextet value by table search, -2 for pad, -1 for anything unmapped
  function automatic int b64_val(input logic [7:0] c);
    if (c == 8'h3D) return -2;
    for (int i = 0; i < 64; i++) if (B64[i] == c) return i;
    return -1;
  endfunction

  function automatic bit ws_char(input logic [7:0] c);
    return (c == 8'h09) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h20);
  endfunction

  // Whole-frame model: fills exp_q, reports first error code and the index of its character
  task automatic model_frame(output int ec, output int ei);
    int grp[$];
    int n;
    int v;
    int val;
    int np;
    bit last;
    bit done;
    logic [7:0] c;
    logic [8:0] e;
    n = frame_q.size();
    ec = 0;
    ei = -1;
    done = 0;
    for (int i = 0; i < n && !done; i++) begin
      c = frame_q[i];
      last = (i == n - 1);
      v = b64_val(c);
      if (WS_SKIP && ws_char(c)) begin
        if (last) begin ec = 3; ei = i; done = 1; end
      end else if (v == -1) begin
        ec = 1; ei = i; done = 1;
      end else if (v == -2 && grp.size() < 2) begin
        ec = 2; ei = i; done = 1;
      end else if (v != -2 && grp.size() == 3 && grp[2] == -2) begin
        ec = 2; ei = i; done = 1;
      end else if (last && grp.size() < 3) begin
        ec = 3; ei = i; done = 1;
      end else begin
        grp.push_back(v);
        if (grp.size() == 4) begin
          val = 0;
          np = 0;
          foreach (grp[j]) begin
            val = val * 64 + ((grp[j] < 0) ? 0 : grp[j]);
            if (grp[j] < 0) np++;
          end
          if (np > 0 && !last) begin
            ec = 2; ei = i; done = 1;
          end else begin
            for (int b = 0; b < 3 - np; b++) begin
              e = {(last && b == 2 - np), 8'((val >> (16 - 8 * b)) & 255)};
              exp_q.push_back(e);
            end
          end
          grp.delete();
        end
      end
    end
  endtask

  task automatic load(input string s);
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
  endtask

  task automatic gen_frame();
    int ng;
    int k;
    ng = $urandom_range(3, 1);
    frame_q.delete();
    for (int i = 0; i < 4 * ng; i++) frame_q.push_back(B64[$urandom_range(63, 0)]);
    k = $urandom_range(3, 0);
    if (k == 1) frame_q[4*ng-1] = 8'h3D;
    if (k == 2) begin frame_q[4*ng-1] = 8'h3D; frame_q[4*ng-2] = 8'h3D; end
    if ($urandom_range(3, 0) == 0) begin
      case ($urandom_range(3, 0))
        0:       frame_q[$urandom_range(4*ng-1, 0)] = bad_chars[$urandom_range(5, 0)];
        1:       void'(frame_q.pop_back());
        2:       frame_q[$urandom_range(4*ng-1, 0)] = 8'h3D;
        default: frame_q.insert($urandom_range(4*ng-1, 0), 8'h0A);
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the final character is accepted
  task automatic send_frame(input int err_idx);
    int n;
    int t;
    n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      if (gap_en != 0 && $urandom_range(3, 0) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      if (STICKY && err_idx >= 0 && i > err_idx) chk("err_sticky", err, 1);
      in_data  = frame_q[i];
      in_last  = (i == n - 1);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        chk("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_check(input int ec);
    int quiet;
    int t;
    quiet = 0;
    t = 0;
    while (quiet < 4 && t < 400) begin
      @(negedge clk);
      t++;
      quiet = out_valid ? 0 : quiet + 1;
    end
    chk("drain_done", out_valid, 0);
    chk("nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("byte", got_q[i], exp_q[i]);
    chk("nerr", got_err_q.size(), (ec != 0) ? 1 : 0);
    if (ec != 0 && got_err_q.size() > 0) chk("err_code", got_err_q[0], ec);
    chk("err_idle", err, 0);
    got_q.delete();
    exp_q.delete();
    got_err_q.delete();
  endtask

  task automatic run_loaded(input bit lat_chk);
    int ec;
    int ei;
    model_frame(ec, ei);
    send_frame(ei);
    if (lat_chk) begin
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 8'h4D);
    end
    drain_check(ec);
  endtask

  task automatic run_frame(input string s);
    load(s);
    run_loaded(1'b0);
  endtask

  // Output side: drives out_ready, logs handshakes and error events, checks stall stability
  initial begin
    logic       stall;
    logic [7:0] sd;
    logic       sl;
    logic       err_prev;
    out_ready = 1'b0;
    stall = 1'b0;
    sd = 8'h00;
    sl = 1'b0;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = ($urandom_range(2, 0) != 0);
        1:       out_ready = 1'b1;
        2:       out_ready = !out_ready;
        default: out_ready = 1'b0;
      endcase
      if (!rst_n) begin
        stall = 1'b0;
        err_prev = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, sd);
          chk("stall_last", out_last, sl);
        end
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        stall = out_valid && !out_ready;
        sd = out_data;
        sl = out_last;
        if (!err) chk("err_code_idle", err_code, 0);
        if (err && !err_prev) got_err_q.push_back(int'(err_code));
        err_prev = err;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    rdy_mode = 1;
    gap_en = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    load("TWFu");
    run_loaded(1'b1);
    run_frame("TWE=");
    run_frame("TQ==");

    rdy_mode = 2;
    run_frame("TWFuTWE=");
    rdy_mode = 1;

    run_frame("TW*uAAAA");
    run_frame("TWFu");
    run_frame("TWF");
    run_frame("T=AA");
    run_frame("TW\nFu");

    rdy_mode = 3;
    load("TWFu");
    send_frame(-1);
    chk("emit_before_rst", out_valid, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_release_in_ready", in_ready, 1);
    chk("rst_mid_no_bytes", got_q.size(), 0);
    got_q.delete();
    got_err_q.delete();
    rdy_mode = 1;
    run_frame("TWFu");

    rdy_mode = 0;
    gap_en = 1;
    for (int f = 0; f < 80; f++) begin
      gen_frame();
      run_loaded(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
